// File: rtl/kl8_kbd_if.sv
// Bus bundle between the CPU IOT/accumulator logic and the KL8 keyboard.
// master = CPU side (drives IOT/INSTR/AC11 and the serial line), slave = keyboard.
interface kl8_kbd_if;
    logic        RXD;
    logic        IOT;
    logic [11:0] INSTR;
    logic        AC11;
    logic [11:0] DOR;
    logic        CLR;
    logic        SKIP;
    logic        FLAG;
    logic        IRQ;

    modport master (
        output RXD, IOT, INSTR, AC11,
        input  DOR, CLR, SKIP, FLAG, IRQ
    );

    modport slave (
        input  RXD, IOT, INSTR, AC11,
        output DOR, CLR, SKIP, FLAG, IRQ
    );
endinterface

// File: rtl/kl8_kbd.sv
// KL8 console keyboard: 8N1 serial receiver plus IOT responder (KSF/KCC/KRS/KRB).
// Define KL8_KIE_EN to add the interrupt-enable flop and the 6035 KIE operation.
module kl8_kbd #(
    parameter int unsigned CLKDIV = 1250,
    parameter logic [5:0]  DEVICE = 6'o03
) (
    input logic       CLK,
    input logic       RESETN,
    kl8_kbd_if.slave  bus
);

    localparam int unsigned   CW        = $clog2(CLKDIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKDIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic [1:0]    sync_q,  sync_d;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rbuf_q,  rbuf_d;
    logic          flag_q,  flag_d;

    logic          rxs_s;
    logic          rxs_fall_s;
    logic          char_done_s;
    logic          sel_s;
    logic [2:0]    op_s;
    logic          kie_s;
    logic          ie_s;
    logic          flag_clr_s;

    assign rxs_s      = sync_q[1];
    // RXS is falling on this edge: the second stage still holds 1 while the first already holds 0.
    assign rxs_fall_s = sync_q[1] & ~sync_q[0];

    assign sel_s = bus.IOT & (bus.INSTR[11:9] == 3'b110) & (bus.INSTR[8:3] == DEVICE);
    assign op_s  = bus.INSTR[2:0];

`ifdef KL8_KIE_EN
    logic ie_q, ie_d;

    assign kie_s = sel_s & (op_s == 3'b101);
    assign ie_s  = ie_q;

    always_comb begin
        if (kie_s) begin
            ie_d = bus.AC11;
        end else begin
            ie_d = ie_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ie_q <= 1'b1;
        end else begin
            ie_q <= ie_d;
        end
    end
`else
    logic unused_ac11_s;

    assign unused_ac11_s = bus.AC11;
    assign kie_s         = 1'b0;
    assign ie_s          = 1'b1;
`endif

    assign flag_clr_s = sel_s & (op_s[1] | (op_s == 3'b000));

    // SKIP samples FLAG before this IOT's own clear lands.
    assign bus.SKIP = sel_s & ~kie_s & op_s[0] & flag_q;
    assign bus.CLR  = sel_s & op_s[1];
    assign bus.DOR  = (sel_s & ~kie_s & op_s[2]) ? {4'b0000, rbuf_q} : 12'd0;
    assign bus.FLAG = flag_q;
    assign bus.IRQ  = flag_q & ie_s;

    always_comb begin
        sync_d      = {sync_q[0], bus.RXD};
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rbuf_d      = rbuf_q;
        char_done_s = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (rxs_fall_s) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!rxs_s) begin
                    state_d = RX_DATA;
                    cnt_d   = BIT_LOAD;
                    idx_d   = 3'd0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shift_d[idx_q] = rxs_s;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // A low stop bit is a framing error: the character is dropped.
                    if (rxs_s) begin
                        rbuf_d      = shift_q;
                        char_done_s = 1'b1;
                    end else begin
                        rbuf_d = rbuf_q;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // A completing character beats a same-cycle clear so nothing is lost.
        if (char_done_s) begin
            flag_d = 1'b1;
        end else if (flag_clr_s) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            rbuf_q  <= 8'd0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            rbuf_q  <= rbuf_d;
            flag_q  <= flag_d;
        end
    end

endmodule
